// File: rtl/riscv_store_monitor.sv
// Passive store-bus monitor: buffers core stores in a FIFO drained over
// valid/ready and runs a RUN/PASS/FAIL self-check on the store stream.
module riscv_store_monitor #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] PASS_ADR    = 32'd100,
    parameter logic [31:0] PASS_DATA   = 32'd25,
    parameter logic [31:0] SCRATCH_ADR = 32'd96
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_adr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done,
    output logic                     pass
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     mem_adr_q  [DEPTH];
    logic [31:0]     mem_data_q [DEPTH];

    logic            store_ev_c;
    logic            empty_c;
    logic            full_c;
    logic            pop_c;
    logic            push_c;

    // FIFO occupancy and handshake decode; X on MemWrite is treated as idle
    always_comb begin
        store_ev_c = (MemWrite === 1'b1) && (state_q == ST_RUN);
        empty_c    = (wr_ptr_q == rd_ptr_q);
        full_c     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_c      = !empty_c && out_ready;
        push_c     = store_ev_c && (!full_c || pop_c);
    end

    // Next pointer and sticky overflow computation
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (store_ev_c && full_c && !pop_c) begin
            overflow_d = 1'b1;
        end
    end

    // Checker next-state: decided by each store seen while running
    always_comb begin
        state_d = state_q;
        if (store_ev_c) begin
            if (DataAdr == PASS_ADR && WriteData == PASS_DATA) begin
                state_d = ST_PASS;
            end else if (DataAdr != SCRATCH_ADR) begin
                state_d = ST_FAIL;
            end
        end
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; not reset, contents are only meaningful when valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_adr_q[wr_ptr_q[AW-1:0]]  <= DataAdr;
            mem_data_q[wr_ptr_q[AW-1:0]] <= WriteData;
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        out_valid = (wr_ptr_q != rd_ptr_q);
        out_adr   = mem_adr_q[rd_ptr_q[AW-1:0]];
        out_data  = mem_data_q[rd_ptr_q[AW-1:0]];
        count     = wr_ptr_q - rd_ptr_q;
        overflow  = overflow_q;
        done      = (state_q != ST_RUN);
        pass      = (state_q == ST_PASS);
    end

endmodule

// File: tb/tb_riscv_store_monitor.sv
// Directed self-checking bench for riscv_store_monitor (DEPTH=8).
module tb_riscv_store_monitor;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_adr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic        done;
    logic        pass;

    int n_checks;
    int n_pass;

    riscv_store_monitor #(
        .DEPTH       (8),
        .PASS_ADR    (32'd100),
        .PASS_DATA   (32'd25),
        .SCRATCH_ADR (32'd96)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_adr   (out_adr),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .done      (done),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        MemWrite = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // One store sampled on the next rising edge; returns 1 time unit after it
    task automatic do_store(input logic [31:0] adr, input logic [31:0] dat);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = dat;
        @(posedge clk);
        #1 MemWrite = 1'b0;
    endtask

    task automatic do_pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    function automatic logic [63:0] ent(input logic [31:0] a, input logic [31:0] d);
        return {a, d};
    endfunction

    logic [31:0] exp_data [8];

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        DataAdr   = '0;
        WriteData = '0;

        // Reset values
        apply_reset();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);

        // Pass sequence, then drain in order
        do_store(32'd96, 32'd7);
        check("p1_count", 64'(count), 64'd1);
        check("p1_valid", 64'(out_valid), 64'd1);
        check("p1_done", 64'(done), 64'd0);
        do_store(32'd96, 32'd9);
        check("p2_done", 64'(done), 64'd0);
        do_store(32'd100, 32'd25);
        check("p3_done", 64'(done), 64'd1);
        check("p3_pass", 64'(pass), 64'd1);
        check("p3_count", 64'(count), 64'd3);
        check("head0", ent(out_adr, out_data), ent(32'd96, 32'd7));
        do_pop();
        check("head1", ent(out_adr, out_data), ent(32'd96, 32'd9));
        do_pop();
        check("head2", ent(out_adr, out_data), ent(32'd100, 32'd25));
        do_pop();
        check("drained_count", 64'(count), 64'd0);
        check("drained_valid", 64'(out_valid), 64'd0);
        do_store(32'd96, 32'd1);
        check("post_pass_ignored", 64'(count), 64'd0);

        // Fail on wrong data; later stores ignored
        apply_reset();
        do_store(32'd100, 32'd24);
        check("fd_done", 64'(done), 64'd1);
        check("fd_pass", 64'(pass), 64'd0);
        check("fd_count", 64'(count), 64'd1);
        do_store(32'd100, 32'd25);
        check("fd_ign_count", 64'(count), 64'd1);
        check("fd_ign_pass", 64'(pass), 64'd0);

        // Fail on wrong address
        apply_reset();
        do_store(32'd104, 32'd25);
        check("fa_done", 64'(done), 64'd1);
        check("fa_pass", 64'(pass), 64'd0);

        // Asynchronous reset mid-run with 3 entries buffered
        apply_reset();
        do_store(32'd96, 32'd1);
        do_store(32'd96, 32'd2);
        do_store(32'd104, 32'd3);
        check("mr_pre_count", 64'(count), 64'd3);
        check("mr_pre_done", 64'(done), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mr_count", 64'(count), 64'd0);
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_done", 64'(done), 64'd0);

        // Overflow: 9 stores into 8 entries
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_store(32'd96, 32'(i));
            if (i == 7) begin
                check("ov_full_count", 64'(count), 64'd8);
                check("ov_full_flag", 64'(overflow), 64'd0);
            end
        end
        check("ov_count", 64'(count), 64'd8);
        check("ov_flag", 64'(overflow), 64'd1);
        check("ov_head", 64'(out_data), 64'd0);
        out_ready = 1'b1;
        do_store(32'd96, 32'd9);
        out_ready = 1'b0;
        check("ov_pp_count", 64'(count), 64'd8);
        check("ov_pp_head", 64'(out_data), 64'd1);
        check("ov_pp_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 7; i++) exp_data[i] = 32'(i + 1);
        exp_data[7] = 32'd9;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ov_drain%0d", i), 64'(out_data), 64'(exp_data[i]));
            do_pop();
        end
        check("ov_drain_empty", 64'(out_valid), 64'd0);

        // Wrap-around with continuous drain
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            MemWrite  = 1'b1;
            DataAdr   = 32'd96;
            WriteData = 32'(i);
            @(posedge clk);
            #1;
            check($sformatf("wr_head%0d", i), ent(out_adr, out_data), ent(32'd96, 32'(i)));
            check($sformatf("wr_count%0d", i), 64'(count), 64'd1);
        end
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
        check("wr_final_count", 64'(count), 64'd0);
        check("wr_ovf", 64'(overflow), 64'd0);
        check("wr_done", 64'(done), 64'd0);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_store_monitor.md
# riscv_store_monitor

Passive observer on the single-cycle RISC-V processor's data-memory write bus (`MemWrite`, `DataAdr`, `WriteData`), downstream of the `top` core. It buffers every store into a small FIFO that a host-side consumer drains over a valid/ready port. It also runs a hardware self-check FSM that declares pass or fail from the store stream. The block lets the regression program run on the FPGA, where no simulator is present.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `PASS_ADR`, 32'd100: store address that can signal success.
- `PASS_DATA`, 32'd25: data value required at `PASS_ADR` for success.
- `SCRATCH_ADR`, 32'd96: address the program may store to freely.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `MemWrite`  in  1: store strobe from the core.
- `DataAdr`  in  32: store byte address.
- `WriteData`  in  32: store data.
- `out_valid`  out  1: FIFO head is valid.
- `out_ready`  in  1: consumer accepts the head.
- `out_adr`  out  32: head entry address.
- `out_data`  out  32: head entry data.
- `count`  out  $clog2(DEPTH)+1: number of occupied entries.
- `overflow`  out  1: sticky; a store was dropped.
- `done`  out  1: checker reached a terminal state.
- `pass`  out  1: checker reached PASS.

## Operation
- **Store event:** rising edge with `MemWrite==1` and checker in RUN. Stores while the checker is in PASS or FAIL are ignored: no push, no overflow.
- **Push:** a store event writes `{DataAdr, WriteData}` at the write pointer.
- **Pop:** `out_valid && out_ready` at a rising edge advances the read pointer.
- **FIFO:**
  - Storage is a register array with read/write pointers of width $clog2(DEPTH)+1, using the MSB to distinguish full from empty.
  - Pointers wrap modulo DEPTH.
  - `out_adr`/`out_data` are driven directly from the entry at the read pointer. They are undefined when `out_valid==0`.
- **Full FIFO, push without pop:** entry dropped, `overflow` set to 1. `overflow` stays 1 until reset.
- **Full FIFO, push with pop in the same edge:** both accepted; `count` unchanged; no overflow.
- **Empty FIFO:** `out_valid=0`; `out_ready` ignored.
- **Checker FSM** (states RUN, PASS, FAIL), evaluated on each store event:
  - `DataAdr==PASS_ADR && WriteData==PASS_DATA` → PASS.
  - Else `DataAdr!=SCRATCH_ADR` → FAIL.
  - Else stay in RUN.
- PASS and FAIL are terminal until reset. The terminating store itself is still pushed, subject to the full rules.
- **Outputs:** `done = (state!=RUN)`; `pass = (state==PASS)`. Both are decoded from registered state only.
- **X on inputs:** comparisons use `==`. An X on `MemWrite` counts as no store event, so the implementation must gate on `MemWrite === 1'b1` in simulation-safe form.

## Timing
- **Reset (`reset==0`):** takes effect asynchronously.
  - Pointers cleared; `count=0`, `out_valid=0`, `overflow=0`.
  - State RUN; `done=0`, `pass=0`.
  - FIFO storage is not cleared.
- **Reset mid-operation:** all buffered entries are discarded; the checker returns to RUN.
- **Reset release:** the first edge at which `reset==1` may already capture a store.
- **Push latency:** 1 cycle. A store sampled at edge N gives `out_valid=1` and `count` incremented after edge N.
- **`done`/`pass` latency:** they change after the same edge that samples the deciding store.
- **Pop:** the head advances after the accepting edge. A new head, if any, is presented in the same cycle.
- **Sustained throughput:** one push and one pop per cycle.
- **Combinational paths:** `out_valid`, `out_adr`, `out_data`, `count`, `done`, `pass` depend only on registers. No combinational path from `out_ready` or the bus inputs to any output.

## Test plan
- **Reset values:** hold `reset=0` for 2 cycles, then release → all outputs 0. Assert `reset=0` mid-run with 3 entries buffered → `count=0`, `out_valid=0`, `done=0` immediately, without waiting for a clock.
- **Pass sequence:** stores (96,7), (96,9), (100,25) with `out_ready=0` → after the third edge `done=1`, `pass=1`, `count=3`. Then pop 3 entries → heads read (96,7), (96,9), (100,25) in order.
- **Fail on wrong data:** store (100,24) → `done=1`, `pass=0`. A subsequent store (100,25) is ignored: `count` stays 1 and `pass` stays 0.
- **Fail on wrong address:** store (104,25) → FAIL after that edge.
- **Overflow:** with `DEPTH=8` and `out_ready=0`, issue 9 stores to address 96 → `count=8` and `overflow=1` after the 9th. Then a push and pop on the same edge → `count` stays 8, no new drop, and the head advances.
- **Wrap-around:** stream 20 stores to 96 with data 0..19 while `out_ready=1` → each entry is observed exactly once in order, `count` never exceeds 1, `overflow=0`.
